// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  typedef tx_state_t rx_state_t;

  // Clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk, input int baud, input int os);
    int d;
    d = clk / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick divider shared by the TX and RX paths.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With DIV=1 the counter sits at zero and the tick is permanently high.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core (data width, stop bits, oversampling, loopback).
// Define UART_PARITY_EN to add a parity bit (parameter PARITY_ODD selects odd parity).
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int LOOPBACK   = 0
`ifdef UART_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

`ifdef UART_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;
  localparam bit PAR_ODD    = (PARITY_ODD != 0);
`else
  localparam bit HAS_PARITY = 1'b0;
  localparam bit PAR_ODD    = 1'b0;
`endif

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CNT_W = $clog2(STOP_BITS * OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  tx_state_t            tx_state, tx_state_nxt;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_nxt;
  logic [IDX_W-1:0]     tx_idx, tx_idx_nxt;
  logic [DATA_BITS-1:0] tx_shreg, tx_shreg_nxt;
  logic                 tx_par, tx_par_nxt, tx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_shreg <= tx_shreg_nxt;
      tx_par   <= tx_par_nxt;
      tx       <= tx_nxt;
    end
  end

  // The serial pin is registered from the next state so it never glitches.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_idx_nxt   = tx_idx;
    tx_shreg_nxt = tx_shreg;
    tx_par_nxt   = tx_par;
    tx_nxt       = 1'b1;
    case (tx_state)
      IDLE: begin
        if (tx_start) begin
          tx_state_nxt = START;
          tx_cnt_nxt   = '0;
          tx_idx_nxt   = '0;
          tx_shreg_nxt = tx_data;
          tx_par_nxt   = (^tx_data) ^ PAR_ODD;
        end
      end
      START: begin
        if (tick) begin
          if (tx_cnt == BIT_END) begin
            tx_state_nxt = DATA;
            tx_cnt_nxt   = '0;
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tx_cnt == BIT_END) begin
            tx_cnt_nxt   = '0;
            tx_shreg_nxt = tx_shreg >> 1;
            tx_idx_nxt   = tx_idx + 1'b1;
            if (tx_idx == IDX_END) begin
              if (HAS_PARITY) tx_state_nxt = PARITY;
              else            tx_state_nxt = STOP;
            end
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (tx_cnt == BIT_END) begin
            tx_state_nxt = STOP;
            tx_cnt_nxt   = '0;
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tx_cnt == STOP_END) begin
            tx_state_nxt = IDLE;
            tx_cnt_nxt   = '0;
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
    case (tx_state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = tx_shreg_nxt[0];
      PARITY:  tx_nxt = tx_par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != IDLE);

  logic sync_in, rx_s1, rx_s2, rx_q, rx_fall;

  assign sync_in = (LOOPBACK != 0) ? tx : rx_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= sync_in;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  // Edge rather than level, so a line still low after a bad stop bit is not a new start.
  assign rx_fall = rx_q & ~rx_s2;

  rx_state_t            rx_state, rx_state_nxt;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_nxt;
  logic [IDX_W-1:0]     rx_idx, rx_idx_nxt;
  logic [DATA_BITS-1:0] rx_shreg, rx_shreg_nxt, rx_data_nxt;
  logic                 rx_par_bad, rx_par_bad_nxt;
  logic                 rx_done_nxt, rx_ferr_nxt, rx_perr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shreg      <= '0;
      rx_par_bad    <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_state      <= rx_state_nxt;
      rx_cnt        <= rx_cnt_nxt;
      rx_idx        <= rx_idx_nxt;
      rx_shreg      <= rx_shreg_nxt;
      rx_par_bad    <= rx_par_bad_nxt;
      rx_data       <= rx_data_nxt;
      rx_done       <= rx_done_nxt;
      rx_frame_err  <= rx_ferr_nxt;
      rx_parity_err <= rx_perr_nxt;
    end
  end

  always_comb begin
    rx_state_nxt   = rx_state;
    rx_cnt_nxt     = rx_cnt;
    rx_idx_nxt     = rx_idx;
    rx_shreg_nxt   = rx_shreg;
    rx_par_bad_nxt = rx_par_bad;
    rx_data_nxt    = rx_data;
    rx_done_nxt    = 1'b0;
    rx_ferr_nxt    = rx_frame_err;
    rx_perr_nxt    = rx_parity_err;
    case (rx_state)
      IDLE: begin
        if (rx_fall) begin
          rx_state_nxt = START;
          rx_cnt_nxt   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (rx_cnt == HALF_END) begin
            rx_cnt_nxt = '0;
            rx_idx_nxt = '0;
            if (rx_s2) rx_state_nxt = IDLE;
            else       rx_state_nxt = DATA;
          end else begin
            rx_cnt_nxt = rx_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rx_cnt == BIT_END) begin
            rx_cnt_nxt   = '0;
            rx_shreg_nxt = {rx_s2, rx_shreg[DATA_BITS-1:1]};
            rx_idx_nxt   = rx_idx + 1'b1;
            if (rx_idx == IDX_END) begin
              if (HAS_PARITY) rx_state_nxt = PARITY;
              else            rx_state_nxt = STOP;
            end
          end else begin
            rx_cnt_nxt = rx_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (rx_cnt == BIT_END) begin
            rx_cnt_nxt     = '0;
            rx_par_bad_nxt = rx_s2 ^ (^rx_shreg) ^ PAR_ODD;
            rx_state_nxt   = STOP;
          end else begin
            rx_cnt_nxt = rx_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        // Only the first stop bit is checked; RX re-arms during any extra ones.
        if (tick) begin
          if (rx_cnt == BIT_END) begin
            rx_cnt_nxt   = '0;
            rx_done_nxt  = 1'b1;
            rx_data_nxt  = rx_shreg;
            rx_ferr_nxt  = ~rx_s2;
            rx_perr_nxt  = HAS_PARITY & rx_par_bad;
            rx_state_nxt = IDLE;
          end else begin
            rx_cnt_nxt = rx_cnt + 1'b1;
          end
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

endmodule
